// File: rtl/bcd_time_counter_if.sv
// bcd_time_counter_if: button/tick inputs and packed-BCD time outputs of the
// time-of-day counter. The counter connects through the slave modport, and
// the block that drives the buttons connects through the master modport.
interface bcd_time_counter_if;
    logic        tick_1hz;
    logic        mode_btn;
    logic        inc_btn;
    logic [23:0] count;
    logic [1:0]  setting;
    logic        rollover;
    logic        pm;

    modport master (
        output tick_1hz, mode_btn, inc_btn,
        input  count, setting, rollover, pm
    );

    modport slave (
        input  tick_1hz, mode_btn, inc_btn,
        output count, setting, rollover, pm
    );
endinterface

// File: rtl/bcd_time_counter.sv
// bcd_time_counter: hours/minutes/seconds held as six packed BCD digits.
// The counter advances on tick_1hz in RUN. A set-time state machine
// (RUN -> SET_HR -> SET_MIN -> RUN) is stepped by mode_btn, and inc_btn
// increments the field being set.
// Optional feature macro: TWELVE_HOUR_EN. When it is defined, hours run
// 12, 01..11 and the pm flag toggles on 11->12. When it is undefined, hours
// run 00..23 and pm stays 0.
module bcd_time_counter #(
    parameter logic [7:0] INIT_HOURS   = 8'h00,
    parameter logic [7:0] INIT_MINUTES = 8'h00
) (
    input  logic              clk,
    input  logic              reset,
    bcd_time_counter_if.slave bus
);

    localparam logic [1:0] ST_RUN     = 2'd0;
    localparam logic [1:0] ST_SET_HR  = 2'd1;
    localparam logic [1:0] ST_SET_MIN = 2'd2;

    logic [23:0] r_count;
    logic [1:0]  r_setting;
    logic        r_rollover;
    logic        r_pm;

    logic [23:0] w_count_nxt;
    logic [1:0]  w_setting_nxt;
    logic        w_rollover_nxt;
    logic        w_pm_nxt;

    logic [7:0]  w_hours;
    logic [7:0]  w_minutes;
    logic [7:0]  w_seconds;
    logic        w_sec_last;
    logic        w_min_last;
    logic        w_hour_last;
    logic        w_hour_flips_pm;

    // Two-digit BCD increment that wraps 59 -> 00 and produces no carry.
    function automatic logic [7:0] inc_mod60(input logic [7:0] v);
        logic [7:0] r;
        if (v[3:0] == 4'h9) begin
            r = (v[7:4] == 4'h5) ? 8'h00 : {v[7:4] + 4'h1, 4'h0};
        end else begin
            r = {v[7:4], v[3:0] + 4'h1};
        end
        return r;
    endfunction

    // Two-digit BCD hour increment with the wrap of the compiled mode.
    function automatic logic [7:0] inc_hours(input logic [7:0] h);
        logic [7:0] r;
`ifdef TWELVE_HOUR_EN
        if (h == 8'h12) begin
            r = 8'h01;
        end
`else
        if (h == 8'h23) begin
            r = 8'h00;
        end
`endif
        else if (h[3:0] == 4'h9) begin
            r = {h[7:4] + 4'h1, 4'h0};
        end else begin
            r = {h[7:4], h[3:0] + 4'h1};
        end
        return r;
    endfunction

    assign w_hours    = r_count[23:16];
    assign w_minutes  = r_count[15:8];
    assign w_seconds  = r_count[7:0];
    assign w_sec_last = (w_seconds == 8'h59);
    assign w_min_last = (w_minutes == 8'h59);

`ifdef TWELVE_HOUR_EN
    // 11 -> 12 flips AM/PM. Only the PM side of that flip ends the day.
    assign w_hour_flips_pm = (w_hours == 8'h11);
    assign w_hour_last     = w_hour_flips_pm & r_pm;
`else
    assign w_hour_flips_pm = 1'b0;
    assign w_hour_last     = (w_hours == 8'h23);
`endif

    // Next-state logic. mode_btn takes priority, and inc/tick in that cycle are dropped.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        w_count_nxt    = r_count;
        w_setting_nxt  = r_setting;
        w_rollover_nxt = 1'b0;
        w_pm_nxt       = r_pm;

        if (bus.mode_btn) begin
            case (r_setting)
                ST_RUN: begin
                    w_setting_nxt     = ST_SET_HR;
                    w_count_nxt[7:0]  = 8'h00;
                end
                ST_SET_HR: w_setting_nxt = ST_SET_MIN;
                default:   w_setting_nxt = ST_RUN;
            endcase
        end else begin
            case (r_setting)
                ST_RUN: begin
                    if (bus.tick_1hz) begin
                        w_count_nxt[7:0] = inc_mod60(w_seconds);
                        if (w_sec_last) begin
                            w_count_nxt[15:8] = inc_mod60(w_minutes);
                            if (w_min_last) begin
                                w_count_nxt[23:16] = inc_hours(w_hours);
                                w_pm_nxt           = r_pm ^ w_hour_flips_pm;
                                w_rollover_nxt     = w_hour_last;
                            end
                        end
                    end
                end
                ST_SET_HR: begin
                    if (bus.inc_btn) begin
                        w_count_nxt[23:16] = inc_hours(w_hours);
                        w_pm_nxt           = r_pm ^ w_hour_flips_pm;
                    end
                end
                ST_SET_MIN: begin
                    if (bus.inc_btn) begin
                        w_count_nxt[15:8] = inc_mod60(w_minutes);
                    end
                end
                default: w_setting_nxt = ST_RUN;
            endcase
        end
    end

    // State registers with synchronous reset to the configured start time.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            r_count    <= {INIT_HOURS, INIT_MINUTES, 8'h00};
            r_setting  <= ST_RUN;
            r_rollover <= 1'b0;
            r_pm       <= 1'b0;
        end else begin
            r_count    <= w_count_nxt;
            r_setting  <= w_setting_nxt;
            r_rollover <= w_rollover_nxt;
            r_pm       <= w_pm_nxt;
        end
    end

    assign bus.count    = r_count;
    assign bus.setting  = r_setting;
    assign bus.rollover = r_rollover;
    assign bus.pm       = r_pm;

endmodule

// File: tb/tb_bcd_time_counter.sv
// tb_bcd_time_counter: randomized and directed checks of bcd_time_counter
// against a seconds-of-day reference model. Define TWELVE_HOUR_EN to check
// the 12-hour build.
module tb_bcd_time_counter;

`ifdef TWELVE_HOUR_EN
    localparam bit         TWELVE     = 1'b1;
    localparam logic [7:0] A_INIT_H   = 8'h12;
    localparam int         A_H24      = 0;
    localparam logic [7:0] B_INIT_H   = 8'h11;
    localparam int         B_H24      = 11;
    localparam logic [7:0] LAST_H     = 8'h11;
    localparam logic [7:0] MIDNIGHT_H = 8'h12;
`else
    localparam bit         TWELVE     = 1'b0;
    localparam logic [7:0] A_INIT_H   = 8'h00;
    localparam int         A_H24      = 0;
    localparam logic [7:0] B_INIT_H   = 8'h23;
    localparam int         B_H24      = 23;
    localparam logic [7:0] LAST_H     = 8'h23;
    localparam logic [7:0] MIDNIGHT_H = 8'h00;
`endif
    localparam int A_INIT_S = A_H24 * 3600;
    localparam int B_INIT_S = B_H24 * 3600 + 59 * 60;

    typedef struct packed {
        int s;
        int st;
        bit roll;
    } mdl_t;

    logic clk = 1'b0;
    logic rst_a = 1'b0;
    logic rst_b = 1'b0;
    mdl_t ma;
    mdl_t mb;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    bcd_time_counter_if ifa ();
    bcd_time_counter_if ifb ();

    bcd_time_counter #(.INIT_HOURS(A_INIT_H), .INIT_MINUTES(8'h00)) dut_a (
        .clk(clk), .reset(rst_a), .bus(ifa)
    );
    bcd_time_counter #(.INIT_HOURS(B_INIT_H), .INIT_MINUTES(8'h59)) dut_b (
        .clk(clk), .reset(rst_b), .bus(ifb)
    );

    // Time of day as plain seconds since midnight, rendered to BCD digits.
    function automatic logic [23:0] exp_count(input int s);
        int h24, hd, m, sec;
        h24 = s / 3600;
        m   = (s / 60) % 60;
        sec = s % 60;
        if (TWELVE) hd = (h24 % 12 == 0) ? 12 : h24 % 12;
        else        hd = h24;
        return {4'(hd / 10), 4'(hd % 10), 4'(m / 10), 4'(m % 10), 4'(sec / 10), 4'(sec % 10)};
    endfunction

    function automatic logic exp_pm(input int s);
        return TWELVE && (s >= 43200);
    endfunction

    function automatic mdl_t mdl_step(input mdl_t m, input bit rst, input bit mode,
                                      input bit inc, input bit tick, input int init_s);
        mdl_t n;
        n = m;
        n.roll = 1'b0;
        if (rst) begin
            n.s  = init_s;
            n.st = 0;
        end else if (mode) begin
            if (m.st == 0) begin
                n.st = 1;
                n.s  = m.s - m.s % 60;
            end else if (m.st == 1) begin
                n.st = 2;
            end else begin
                n.st = 0;
            end
        end else if (m.st == 0 && tick) begin
            n.s = m.s + 1;
            if (n.s == 86400) begin
                n.s    = 0;
                n.roll = 1'b1;
            end
        end else if (m.st == 1 && inc) begin
            n.s = ((m.s / 3600 + 1) % 24) * 3600 + m.s % 3600;
        end else if (m.st == 2 && inc) begin
            n.s = (m.s / 3600) * 3600 + (((m.s / 60) % 60 + 1) % 60) * 60 + m.s % 60;
        end
        return n;
    endfunction

    function automatic logic [27:0] exp_of(input mdl_t m);
        return {exp_count(m.s), 2'(m.st), m.roll, exp_pm(m.s)};
    endfunction

    function automatic logic [27:0] obs_a();
        return {ifa.count, ifa.setting, ifa.rollover, ifa.pm};
    endfunction

    function automatic logic [27:0] obs_b();
        return {ifb.count, ifb.setting, ifb.rollover, ifb.pm};
    endfunction

    task automatic step_a(input bit rst, input bit mode, input bit inc, input bit tick);
        rst_a = rst; ifa.mode_btn = mode; ifa.inc_btn = inc; ifa.tick_1hz = tick;
        @(posedge clk); #1;
        ma = mdl_step(ma, rst, mode, inc, tick, A_INIT_S);
        rst_a = 1'b0; ifa.mode_btn = 1'b0; ifa.inc_btn = 1'b0; ifa.tick_1hz = 1'b0;
    endtask

    task automatic step_b(input bit rst, input bit mode, input bit inc, input bit tick);
        rst_b = rst; ifb.mode_btn = mode; ifb.inc_btn = inc; ifb.tick_1hz = tick;
        @(posedge clk); #1;
        mb = mdl_step(mb, rst, mode, inc, tick, B_INIT_S);
        rst_b = 1'b0; ifb.mode_btn = 1'b0; ifb.inc_btn = 1'b0; ifb.tick_1hz = 1'b0;
    endtask

    task automatic test_reset();
        step_a(1'b1, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (obs_a() !== {A_INIT_H, 16'h0000, 2'd0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_a: got %h expected %h", obs_a(), {A_INIT_H, 16'h0000, 4'h0});
        end
        step_b(1'b1, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (obs_b() !== {B_INIT_H, 8'h59, 8'h00, 2'd0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_b: got %h expected %h", obs_b(), {B_INIT_H, 8'h59, 8'h00, 4'h0});
        end
    endtask

    task automatic test_count_61();
        step_a(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 61; i++) begin
            step_a(1'b0, 1'b0, 1'b0, 1'b1);
            n_checks++;
            if (obs_a() !== exp_of(ma)) begin
                n_fail++;
                $display("FAIL count61 tick %0d: got %h expected %h", i, obs_a(), exp_of(ma));
            end
        end
        n_checks++;
        if (ifa.count !== {A_INIT_H, 8'h01, 8'h01} || ifa.rollover !== 1'b0) begin
            n_fail++;
            $display("FAIL count61_final: got %h expected %h", ifa.count, {A_INIT_H, 16'h0101});
        end
    endtask

    task automatic test_rollover();
        step_b(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 59; i++) begin
            step_b(1'b0, 1'b0, 1'b0, 1'b1);
            n_checks++;
            if (obs_b() !== exp_of(mb)) begin
                n_fail++;
                $display("FAIL wrap_ticks %0d: got %h expected %h", i, obs_b(), exp_of(mb));
            end
        end
        n_checks++;
        if (ifb.count !== {B_INIT_H, 16'h5959}) begin
            n_fail++;
            $display("FAIL wrap_pre: got %h expected %h", ifb.count, {B_INIT_H, 16'h5959});
        end
        step_b(1'b0, 1'b0, 1'b0, 1'b1);
        n_checks++;
        if (obs_b() !== exp_of(mb)) begin
            n_fail++;
            $display("FAIL wrap_edge: got %h expected %h", obs_b(), exp_of(mb));
        end
        step_b(1'b0, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (ifb.rollover !== 1'b0 || obs_b() !== exp_of(mb)) begin
            n_fail++;
            $display("FAIL wrap_after: got %h expected %h", obs_b(), exp_of(mb));
        end
    endtask

    task automatic test_twelve_hour();
        for (int i = 0; i < 3599; i++) step_b(1'b0, 1'b0, 1'b0, 1'b1);
        n_checks++;
        if (ifb.count !== 24'h125959 || ifb.pm !== 1'b1 || obs_b() !== exp_of(mb)) begin
            n_fail++;
            $display("FAIL twelve_1259: got %h expected %h", obs_b(), exp_of(mb));
        end
        step_b(1'b0, 1'b0, 1'b0, 1'b1);
        n_checks++;
        if (ifb.count !== 24'h010000 || ifb.pm !== 1'b1 || obs_b() !== exp_of(mb)) begin
            n_fail++;
            $display("FAIL twelve_0100: got %h expected %h", obs_b(), exp_of(mb));
        end
    endtask

    task automatic test_day_wrap_via_set();
        int k, mm;
        k  = (23 - mb.s / 3600 + 24) % 24;
        mm = (59 - (mb.s / 60) % 60 + 60) % 60;
        step_b(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < k; i++) step_b(1'b0, 1'b0, 1'b1, 1'b0);
        step_b(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < mm; i++) step_b(1'b0, 1'b0, 1'b1, 1'b0);
        step_b(1'b0, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if (ifb.count !== {LAST_H, 16'h5900} || obs_b() !== exp_of(mb)) begin
            n_fail++;
            $display("FAIL dayset_last: got %h expected %h", obs_b(), exp_of(mb));
        end
        for (int i = 0; i < 60; i++) begin
            step_b(1'b0, 1'b0, 1'b0, 1'b1);
            n_checks++;
            if (obs_b() !== exp_of(mb)) begin
                n_fail++;
                $display("FAIL dayset_tick %0d: got %h expected %h", i, obs_b(), exp_of(mb));
            end
        end
        n_checks++;
        if (ifb.rollover !== 1'b1 || ifb.count !== {MIDNIGHT_H, 16'h0000} || ifb.pm !== 1'b0) begin
            n_fail++;
            $display("FAIL dayset_wrap: got %h expected %h", obs_b(), {MIDNIGHT_H, 16'h0, 4'b0010});
        end
    endtask

    task automatic test_set_sequence();
        step_a(1'b1, 1'b0, 1'b0, 1'b0);
        step_a(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step_a(1'b0, 1'b0, 1'b1, 1'(i % 2));
        step_a(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 61; i++) begin
            step_a(1'b0, 1'b0, 1'b1, 1'(i % 3 == 0));
            n_checks++;
            if (obs_a() !== exp_of(ma)) begin
                n_fail++;
                $display("FAIL setseq_min %0d: got %h expected %h", i, obs_a(), exp_of(ma));
            end
        end
        step_a(1'b0, 1'b1, 1'b0, 1'b1);
        n_checks++;
        if (ifa.count !== 24'h050100 || ifa.setting !== 2'd0 || ifa.rollover !== 1'b0) begin
            n_fail++;
            $display("FAIL setseq_final: got %h expected %h", obs_a(), {24'h050100, 4'h0});
        end
    endtask

    task automatic test_set_fields();
        int mm;
        step_a(1'b0, 1'b1, 1'b0, 1'b0);
        step_a(1'b0, 1'b1, 1'b0, 1'b0);
        mm = (59 - (ma.s / 60) % 60 + 60) % 60;
        for (int i = 0; i < mm; i++) step_a(1'b0, 1'b0, 1'b1, 1'b0);
        n_checks++;
        if (ifa.count !== 24'h055900 || ifa.setting !== 2'd2) begin
            n_fail++;
            $display("FAIL fields_59: got %h expected %h", obs_a(), {24'h055900, 4'b1000});
        end
        step_a(1'b0, 1'b0, 1'b1, 1'b0);
        n_checks++;
        if (ifa.count !== 24'h050000 || obs_a() !== exp_of(ma)) begin
            n_fail++;
            $display("FAIL fields_nocarry: got %h expected %h", obs_a(), exp_of(ma));
        end
        step_a(1'b0, 1'b1, 1'b1, 1'b0);
        n_checks++;
        if (ifa.count !== 24'h050000 || ifa.setting !== 2'd0) begin
            n_fail++;
            $display("FAIL fields_mode_inc: got %h expected %h", obs_a(), {24'h050000, 4'h0});
        end
    endtask

    task automatic test_simultaneous();
        for (int i = 0; i < 3; i++) step_a(1'b0, 1'b0, 1'b0, 1'b1);
        step_a(1'b0, 1'b1, 1'b0, 1'b1);
        n_checks++;
        if (ifa.count !== 24'h050000 || ifa.setting !== 2'd1) begin
            n_fail++;
            $display("FAIL sim_mode_tick: got %h expected %h", obs_a(), {24'h050000, 4'b0100});
        end
        step_a(1'b0, 1'b1, 1'b0, 1'b0);
        step_a(1'b0, 1'b1, 1'b0, 1'b1);
        n_checks++;
        if (ifa.count !== 24'h050000 || ifa.setting !== 2'd0) begin
            n_fail++;
            $display("FAIL sim_exit_tick: got %h expected %h", obs_a(), {24'h050000, 4'h0});
        end
        step_a(1'b0, 1'b0, 1'b0, 1'b1);
        step_a(1'b0, 1'b0, 1'b1, 1'b0);
        n_checks++;
        if (ifa.count !== 24'h050001 || obs_a() !== exp_of(ma)) begin
            n_fail++;
            $display("FAIL sim_resume: got %h expected %h", obs_a(), exp_of(ma));
        end
    endtask

    task automatic test_reset_mid_set();
        step_a(1'b1, 1'b0, 1'b0, 1'b0);
        step_a(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) step_a(1'b0, 1'b0, 1'b1, 1'b0);
        step_a(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 15; i++) step_a(1'b0, 1'b0, 1'b1, 1'b0);
        n_checks++;
        if (ifa.count !== 24'h071500 || ifa.setting !== 2'd2) begin
            n_fail++;
            $display("FAIL midset_pre: got %h expected %h", obs_a(), {24'h071500, 4'b1000});
        end
        step_a(1'b1, 1'b1, 1'b1, 1'b1);
        n_checks++;
        if (ifa.count !== {A_INIT_H, 16'h0000} || ifa.setting !== 2'd0 || ifa.pm !== 1'b0) begin
            n_fail++;
            $display("FAIL midset_reset: got %h expected %h", obs_a(), {A_INIT_H, 16'h0, 4'h0});
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 4000; i++) begin
            step_a(1'($urandom_range(499) == 0), 1'($urandom_range(39) == 0),
                   1'($urandom_range(3) == 0), 1'($urandom_range(2) == 0));
            n_checks++;
            if (obs_a() !== exp_of(ma)) begin
                n_fail++;
                $display("FAIL random cyc %0d: got %h expected %h", i, obs_a(), exp_of(ma));
            end
        end
    endtask

    initial begin
        ifa.mode_btn = 1'b0; ifa.inc_btn = 1'b0; ifa.tick_1hz = 1'b0;
        ifb.mode_btn = 1'b0; ifb.inc_btn = 1'b0; ifb.tick_1hz = 1'b0;
        ma = '0;
        mb = '0;
        test_reset();
        test_count_61();
        test_rollover();
        if (TWELVE) test_twelve_hour();
        test_day_wrap_via_set();
        test_set_sequence();
        test_set_fields();
        test_simultaneous();
        test_reset_mid_set();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
